// File: rtl/xbox_xlr_apb_regs.sv
// xbox_xlr_apb_regs: APB register file feeding an accelerator slot
module xbox_xlr_apb_regs #(
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] RO_MASK     = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [11:0]       paddr,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        pstrb,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [31:0][31:0] host_regs,
  output logic [31:0]       host_regs_valid_pulse,
  input  logic [31:0][31:0] host_regs_data_out,
  input  logic [31:0]       host_regs_valid_out
);
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam logic [3:0] LP_WS = 4'(WAIT_STATES);
  state_t      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [4:0]  w_idx;
  logic        w_err, w_done, w_we;
  logic [31:0] w_rd;
  assign w_idx   = paddr[6:2];
  assign w_err   = (paddr[1:0] != 2'b0) || (paddr[11:7] != 5'b0) || (pwrite && RO_MASK[w_idx]);
  assign w_done  = (r_state == ACCESS) && psel && (r_cnt == 4'd0);
  assign w_we    = w_done && pwrite && !w_err;
  assign w_rd    = host_regs_valid_out[w_idx] ? host_regs_data_out[w_idx] : host_regs[w_idx];
  assign pready  = w_done;
  assign pslverr = w_done && w_err;
  assign prdata  = (w_done && !w_err && !pwrite) ? w_rd : 32'h0;
  // next state: a setup phase arms the wait counter; completion or a dropped psel ends the transfer
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (r_state == IDLE) begin
      w_state_next = (psel && !penable) ? ACCESS : IDLE;
      w_cnt_next   = (psel && !penable) ? LP_WS : r_cnt;
    end else begin
      w_state_next = (!psel || r_cnt == 4'd0) ? IDLE : ACCESS;
      w_cnt_next   = (!psel || r_cnt == 4'd0) ? r_cnt : r_cnt - 4'd1;
    end
  end
  // FSM state and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end
  // byte-strobed register update and the matching one-cycle write pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_regs             <= '0;
      host_regs_valid_pulse <= '0;
    end else begin
      host_regs_valid_pulse <= w_we ? (32'h1 << w_idx) : 32'h0;
      for (int k = 0; k < 4; k++)
        if (w_we && pstrb[k]) host_regs[w_idx][8*k +: 8] <= pwdata[8*k +: 8];
    end
  end
endmodule

// File: tb/tb_xbox_xlr_apb_regs.sv
// tb_xbox_xlr_apb_regs: table-driven, directed and randomized checks against a register-array model
module tb_xbox_xlr_apb_regs;
  logic              clk = 1'b0;
  logic              rst_n   [2];
  logic              psel    [2];
  logic              penable [2];
  logic              pwrite  [2];
  logic [11:0]       paddr   [2];
  logic [31:0]       pwdata  [2];
  logic [3:0]        pstrb   [2];
  logic [31:0]       prdata  [2];
  logic              pready  [2];
  logic              pslverr [2];
  logic [31:0][31:0] hr      [2];
  logic [31:0]       pulse   [2];
  logic [31:0][31:0] dout    [2];
  logic [31:0]       vout    [2];
  logic [31:0]       mdl     [2][32];
  int                cmp = 0;
  int                errs = 0;
  int                ws [2] = '{0, 3};
  logic [31:0]       ro [2] = '{32'h8, 32'h0};

  always #5 clk = ~clk;

  xbox_xlr_apb_regs #(.WAIT_STATES(0), .RO_MASK(32'h8)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]), .prdata(prdata[0]), .pready(pready[0]),
    .pslverr(pslverr[0]), .host_regs(hr[0]), .host_regs_valid_pulse(pulse[0]),
    .host_regs_data_out(dout[0]), .host_regs_valid_out(vout[0]));

  xbox_xlr_apb_regs #(.WAIT_STATES(3), .RO_MASK(32'h0)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]), .prdata(prdata[1]), .pready(pready[1]),
    .pslverr(pslverr[1]), .host_regs(hr[1]), .host_regs_valid_pulse(pulse[1]),
    .host_regs_data_out(dout[1]), .host_regs_valid_out(vout[1]));

  typedef struct {
    bit          wr;
    logic [11:0] a;
    logic [31:0] wd;
    logic [3:0]  st;
    bit          vo;
    logic [31:0] rd;
    bit          er;
  } vec_t;
  vec_t tv [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_matches(input int d);
    for (int i = 0; i < 32; i++) if (hr[d][i] !== mdl[d][i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic xfer(input int d, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic er, output int n,
                      output logic [31:0] p1, output logic [31:0] p2, output logic wz);
    @(posedge clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    n = 1;
    wz = 1'b1;
    @(negedge clk);
    while (!pready[d] && n < 40) begin
      if (prdata[d] !== 32'h0) wz = 1'b0;
      @(posedge clk); #1;
      n++;
      @(negedge clk);
    end
    rd = prdata[d];
    er = pslverr[d];
    cmp++;
    if (pready[d] !== 1'b1) begin
      errs++;
      $display("FAIL timeout: pready never rose on dut%0d after %0d cycles", d, n);
    end
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    p1 = pulse[d];
    @(posedge clk); #1;
    p2 = pulse[d];
  endtask

  task automatic do_xfer(input int d, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input logic [31:0] exp_rd, input bit exp_er, input string nm);
    logic [31:0] rd, p1, p2, ep;
    logic        er, wz;
    int          n;
    xfer(d, wr, a, wd, st, rd, er, n, p1, p2, wz);
    chk({nm, " pslverr"}, 32'(er), 32'(exp_er));
    if (!wr) chk({nm, " prdata"}, rd, exp_rd);
    chk({nm, " access cycles"}, n, ws[d] + 1);
    chk({nm, " prdata zero in wait"}, 32'(wz), 32'h1);
    ep = (wr && !exp_er) ? (32'h1 << a[6:2]) : 32'h0;
    chk({nm, " pulse"}, p1, ep);
    chk({nm, " pulse cleared"}, p2, 32'h0);
    if (wr && !exp_er)
      for (int k = 0; k < 4; k++) if (st[k]) mdl[d][a[6:2]][8*k +: 8] = wd[8*k +: 8];
    chk({nm, " host_regs vs model"}, 32'(model_matches(d)), 32'h1);
  endtask

  task automatic rand_xfer(input int d);
    logic [11:0] a;
    logic [31:0] wd, erd;
    logic [4:0]  i;
    bit          wr, er;
    int          r;
    wr = 1'($urandom);
    i = 5'($urandom);
    r = $urandom_range(0, 7);
    a = {5'h0, i, 2'b00};
    if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
    if (r == 1) a[11:7] = 5'($urandom_range(1, 31));
    wd = $urandom;
    vout[d] = $urandom;
    for (int k = 0; k < 32; k++) dout[d][k] = $urandom;
    er = (a[1:0] != 0) || (a[11:7] != 0) || (wr && ro[d][a[6:2]]);
    erd = er ? 32'h0 : (vout[d][a[6:2]] ? dout[d][a[6:2]] : mdl[d][a[6:2]]);
    do_xfer(d, wr, a, wd, 4'($urandom), erd, er, "rand");
  endtask

  initial begin
    logic [31:0] acc;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0; vout[d] = '0; dout[d] = '0;
      for (int i = 0; i < 32; i++) mdl[d][i] = '0;
    end
    tv[0]  = '{1, 12'h014, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0};
    tv[1]  = '{1, 12'h014, 32'h00001234, 4'h3, 0, 32'h0, 0};
    tv[2]  = '{0, 12'h014, 32'h0, 4'h0, 0, 32'hDEAD1234, 0};
    tv[3]  = '{1, 12'h002, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1};
    tv[4]  = '{1, 12'h080, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1};
    tv[5]  = '{1, 12'h00C, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1};
    tv[6]  = '{0, 12'h00C, 32'h0, 4'h0, 0, 32'h0, 0};
    tv[7]  = '{0, 12'h080, 32'h0, 4'h0, 0, 32'h0, 1};
    tv[8]  = '{1, 12'h01C, 32'h11112222, 4'hF, 0, 32'h0, 0};
    tv[9]  = '{0, 12'h01C, 32'h0, 4'h0, 1, 32'hCAFE0001, 0};
    tv[10] = '{0, 12'h01C, 32'h0, 4'h0, 0, 32'h11112222, 0};
    tv[11] = '{1, 12'h014, 32'hAAAAAAAA, 4'h0, 0, 32'h0, 0};
    tv[12] = '{0, 12'h014, 32'h0, 4'h0, 0, 32'hDEAD1234, 0};
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset dut%0d host_regs zero", d), 32'(hr[d] == '0), 32'h1);
      chk($sformatf("reset dut%0d pulse", d), pulse[d], 32'h0);
      chk($sformatf("reset dut%0d pready", d), 32'(pready[d]), 32'h0);
      chk($sformatf("reset dut%0d prdata", d), prdata[d], 32'h0);
      rst_n[d] = 1'b1;
    end
    for (int i = 0; i < 32; i++) do_xfer(0, 0, 12'(i * 4), 32'h0, 4'h0, 32'h0, 0, $sformatf("init read %0d", i));
    dout[0][7] = 32'hCAFE0001;
    for (int t = 0; t < 13; t++) begin
      vout[0][7] = tv[t].vo;
      do_xfer(0, tv[t].wr, tv[t].a, tv[t].wd, tv[t].st, tv[t].rd, tv[t].er, $sformatf("vec %0d", t));
    end
    do_xfer(1, 1, 12'h004, 32'h01234567, 4'hF, 32'h0, 0, "ws3 write idx1");
    @(posedge clk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 12'h004; pwdata[1] = 32'hFFFF0000; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    chk("abort pready during wait", 32'(pready[1]), 32'h0);
    @(posedge clk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    acc = '0;
    repeat (4) begin
      @(posedge clk); #1;
      acc |= pulse[1];
    end
    chk("abort no pulse", acc, 32'h0);
    chk("abort host_regs[1] kept", hr[1][1], 32'h01234567);
    do_xfer(1, 1, 12'h008, 32'h00000055, 4'hF, 32'h0, 0, "pre-reset write idx2");
    @(posedge clk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 12'h008; pwdata[1] = 32'h000000AA; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    #1;
    chk("midreset host_regs zero", 32'(hr[1] == '0), 32'h1);
    chk("midreset pulse", pulse[1], 32'h0);
    chk("midreset pready", 32'(pready[1]), 32'h0);
    chk("midreset prdata", prdata[1], 32'h0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    for (int i = 0; i < 32; i++) mdl[1][i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n[1] = 1'b1;
    acc = '0;
    repeat (3) begin
      @(posedge clk); #1;
      acc |= pulse[1];
    end
    chk("postreset no pulse", acc, 32'h0);
    do_xfer(1, 0, 12'h008, 32'h0, 4'h0, 32'h0, 0, "postreset read idx2");
    do_xfer(1, 1, 12'h008, 32'h00000077, 4'hF, 32'h0, 0, "postreset write idx2");
    for (int r = 0; r < 150; r++) rand_xfer(0);
    for (int r = 0; r < 30; r++) rand_xfer(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
